fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of control_unit.
- Owns the fetch PC and issues word reads to unified_memory over a req/ack handshake.
- Buffers fetched instructions in a small prefetch queue and presents them to the control unit with a valid/ready handshake.
- Supports PC redirect (jump/branch) with queue flush and discard of any in-flight read.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset PC, FSM states and queue entry type for the fetch stage
package fetch_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue of {pc, instr} entries with push, pop and flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [CNT_W-1:0]   count,
    output fetch_entry_t       head,
    output logic               full,
    output logic               empty
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Flush wins over push; a pop in the flush cycle is simply absorbed by the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, memory read FSM and prefetch queue; FETCH_BYPASS_EN forwards ack data straight to the consumer
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t     state;
    logic [ADDR_W-1:0] fetch_pc;
    logic             push_ok;
    logic             q_push;
    logic             q_pop;
    logic [CNT_W-1:0] q_count;
    fetch_entry_t     q_head;
    fetch_entry_t     push_entry;
    logic             q_full;
    logic             q_empty;

    assign push_ok    = (state == REQ) & mem_ack & ~redirect;
    assign push_entry = '{pc: fetch_pc, instr: mem_rdata};

`ifdef FETCH_BYPASS_EN
    logic bypass;

    // Empty queue plus a good ack: hand the word over in the ack cycle itself.
    assign bypass      = push_ok & q_empty;
    assign instr_valid = ~q_empty | bypass;
    assign instr       = bypass ? mem_rdata : q_head.instr;
    assign instr_pc    = bypass ? fetch_pc  : q_head.pc;
    assign q_push      = push_ok & ~q_full & ~(bypass & instr_ready);
    assign q_pop       = ~q_empty & instr_ready;
`else
    assign instr_valid = ~q_empty;
    assign instr       = q_head.instr;
    assign instr_pc    = q_head.pc;
    assign q_push      = push_ok & ~q_full;
    assign q_pop       = instr_valid & instr_ready;
`endif

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (q_pop),
        .flush     (redirect),
        .count     (q_count),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    // One outstanding read at most; DROP waits out a read made stale by a redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
        end else begin
            unique case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                    end else if (fetch_en && (q_count < CNT_W'(DEPTH))) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            state <= DROP;
                        end
                    end else if (mem_ack) begin
                        fetch_pc <= fetch_pc + 1'b1;
                        mem_req  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                DROP: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                    end
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a one-cycle-latency memory model
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;

    fetch_unit #(.DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] exp_pc_q [$];
    logic [15:0] exp_in_q [$];
    string       chk_name_q [$];
    logic [31:0] chk_act_q [$];
    logic [31:0] chk_exp_q [$];
    bit          mem_auto;
    int          mem_wait;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        chk_name_q.push_back(name);
        chk_act_q.push_back(act);
        chk_exp_q.push_back(exp);
    endfunction

    function automatic void expect_instr(logic [15:0] pc);
        logic [15:0] v;
        v = 16'hA000 + pc;
        exp_pc_q.push_back(pc);
        exp_in_q.push_back(v);
    endfunction

    string       m_name;
    logic [31:0] m_act;
    logic [31:0] m_exp;
    logic [15:0] m_pc;
    logic [15:0] m_in;

    always @(negedge clk) begin
        while (chk_name_q.size() > 0) begin
            m_name = chk_name_q.pop_front();
            m_act  = chk_act_q.pop_front();
            m_exp  = chk_exp_q.pop_front();
            n_cmp++;
            if (m_act !== m_exp) begin
                n_fail++;
                $display("FAIL %s: got %0h expected %0h", m_name, m_act, m_exp);
            end
        end
        if (reset && instr_valid && instr_ready) begin
            n_cmp++;
            if (exp_pc_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_instr: got pc %0h instr %0h expected none", instr_pc, instr);
            end else begin
                m_pc = exp_pc_q.pop_front();
                m_in = exp_in_q.pop_front();
                if (instr_pc !== m_pc || instr !== m_in) begin
                    n_fail++;
                    $display("FAIL instr_seq: got pc %0h instr %0h expected pc %0h instr %0h",
                             instr_pc, instr, m_pc, m_in);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_auto) begin
            if (mem_ack) begin
                mem_ack  = 1'b0;
                mem_wait = 0;
            end else if (mem_req) begin
                if (mem_wait >= 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 16'hA000 + mem_addr;
                end else begin
                    mem_wait++;
                end
            end else begin
                mem_wait = 0;
            end
        end
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        fetch_en    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        instr_ready = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0;
        mem_auto    = 1'b1;
        mem_wait    = 0;
        exp_pc_q.delete();
        exp_in_q.delete();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_drain(string name);
        for (int i = 0; i < 200 && exp_pc_q.size() != 0; i++) tick();
        check({"drain_", name}, exp_pc_q.size(), 0);
    endtask

    task automatic wait_req_rise(output bit ok);
        bit p;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            p = mem_req;
            tick();
            if (mem_req && !p) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    bit          ok;
    bit          found;
    int          reqs;
    bit          p;
    logic [15:0] wrap_addr [3];

    initial begin
        // Reset state
        do_reset();
        reset = 1'b0;
        tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);

        // Streaming fetch
        do_reset();
        expect_instr(16'h0000);
        expect_instr(16'h0001);
        expect_instr(16'h0002);
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        wait_drain("stream");
        instr_ready = 1'b0;
        fetch_en    = 1'b0;

        // Backpressure: queue fills, fetching stops, then resumes at pc 2
        do_reset();
        fetch_en = 1'b1;
        reqs = 0;
        for (int i = 0; i < 12; i++) begin
            p = mem_req;
            tick();
            if (mem_req && !p) reqs++;
        end
        check("stall_req_count", reqs, 2);
        check("stall_req_low", mem_req, 0);
        check("stall_valid", instr_valid, 1);
        expect_instr(16'h0000);
        expect_instr(16'h0001);
        expect_instr(16'h0002);
        instr_ready = 1'b1;
        wait_drain("stall");
        instr_ready = 1'b0;
        fetch_en    = 1'b0;

        // Redirect while pc 3 is outstanding; late ack carries DEAD
        do_reset();
        expect_instr(16'h0000);
        expect_instr(16'h0001);
        expect_instr(16'h0002);
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (mem_req && mem_addr == 16'h0003 && !mem_ack) found = 1'b1;
        end
        check("drop_req3_seen", found, 1);
        mem_auto    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        check("drop_req_held", mem_req, 1);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_ack  = 1'b0;
        mem_wait = 0;
        mem_auto = 1'b1;
        expect_instr(16'h0040);
        wait_drain("drop");
        fetch_en    = 1'b0;
        instr_ready = 1'b0;

        // Redirect in the same cycle as an ack
        do_reset();
        expect_instr(16'h0000);
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        wait_drain("same_a");
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_ack) found = 1'b1;
            else tick();
        end
        check("same_ack_seen", found, 1);
        redirect    = 1'b1;
        redirect_pc = 16'h0080;
        tick();
        redirect = 1'b0;
        check("same_queue_empty", instr_valid, 0);
        wait_req_rise(ok);
        check("same_req_seen", ok, 1);
        check("same_next_addr", mem_addr, 16'h0080);
        expect_instr(16'h0080);
        wait_drain("same_b");
        fetch_en    = 1'b0;
        instr_ready = 1'b0;

        // Address wrap after redirect in IDLE
        do_reset();
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        fetch_en = 1'b1;
        expect_instr(16'hFFFE);
        expect_instr(16'hFFFF);
        expect_instr(16'h0000);
        wrap_addr[0] = 16'hFFFE;
        wrap_addr[1] = 16'hFFFF;
        wrap_addr[2] = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            wait_req_rise(ok);
            check("wrap_req_seen", ok, 1);
            check("wrap_addr", mem_addr, wrap_addr[i]);
        end
        fetch_en = 1'b0;
        wait_drain("wrap");
        instr_ready = 1'b0;

        // Reset during a request, then a stray ack
        do_reset();
        fetch_en = 1'b1;
        mem_auto = 1'b0;
        wait_req_rise(ok);
        check("arst_req_seen", ok, 1);
        reset = 1'b0;
        #1;
        check("arst_mem_req", mem_req, 0);
        check("arst_mem_addr", mem_addr, 16'h0000);
        check("arst_valid", instr_valid, 0);
        tick();
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        check("arst_req_after", mem_req, 1);
        check("arst_first_addr", mem_addr, 16'h0000);
        mem_wait = 0;
        mem_auto = 1'b1;
        expect_instr(16'h0000);
        instr_ready = 1'b1;
        wait_drain("arst");
        fetch_en    = 1'b0;
        instr_ready = 1'b0;

        // Fetch-to-decode latency on an empty queue
        do_reset();
        fetch_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (mem_ack) found = 1'b1;
        end
        check("lat_ack_seen", found, 1);
`ifdef FETCH_BYPASS_EN
        check("lat_valid_in_ack", instr_valid, 1);
        check("lat_instr_in_ack", instr, 16'hA000);
`else
        check("lat_valid_in_ack", instr_valid, 0);
`endif
        tick();
        fetch_en = 1'b0;
        check("lat_valid_after", instr_valid, 1);
        check("lat_pc_after", instr_pc, 16'h0000);
        check("lat_instr_after", instr, 16'hA000);
        expect_instr(16'h0000);
        instr_ready = 1'b1;
        wait_drain("lat");
        instr_ready = 1'b0;

        tick();
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
